// File: rtl/tempdiv_reader.sv
// tempdiv_reader: read-side streamer for the 13-bit x 2048 coefficient RAMs of the
// SNTRUP757 division/inversion datapath. A start pulse captures a window
// (base address, length, direction). The block then walks the RAM's asynchronous
// read port across that window and presents each word on a valid/ready stream,
// with a last marker on the final beat. A one-cycle done pulse closes the transfer.
module tempdiv_reader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  input  logic                     reverse,
  output logic [RAM_ADDR_BITS-1:0] read_address,
  input  logic [RAM_WIDTH-1:0]     output_data,
  output logic [RAM_WIDTH-1:0]     coef_data,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic                     coef_last,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);
  localparam logic [RAM_ADDR_BITS:0]   REM_ONE  = (RAM_ADDR_BITS + 1)'(1);
  localparam logic [RAM_ADDR_BITS:0]   REM_ZERO = '0;

  // Next read address. The address wraps naturally modulo the RAM depth, so a
  // full-depth window ends back on its base address.
  function automatic logic [RAM_ADDR_BITS-1:0] step_addr(
    input logic [RAM_ADDR_BITS-1:0] addr,
    input logic                     dec
  );
    if (dec) begin
      step_addr = addr - ADDR_ONE;
    end else begin
      step_addr = addr + ADDR_ONE;
    end
  endfunction

  state_t                   state_q,     state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q,      addr_d;
  logic [RAM_ADDR_BITS:0]   remaining_q, remaining_d;
  logic                     dir_q,       dir_d;
  logic [RAM_WIDTH-1:0]     data_q,      data_d;
  logic                     valid_q,     valid_d;
  logic                     last_q,      last_d;
  logic                     busy_q,      busy_d;
  logic                     done_q,      done_d;
  logic                     load;
  logic                     drain;

  // Next-state and registered-output logic for the IDLE/STREAM/FINISH sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load        = 1'b0;
    drain       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = length;
          dir_d       = reverse;
          busy_d      = 1'b1;
          // A zero-length window skips straight to completion without a beat.
          if (length == REM_ZERO) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end

      ST_STREAM: begin
        // A new word is captured whenever the output register is empty or is
        // being emptied this cycle; otherwise everything holds under stall.
        load  = (remaining_q != REM_ZERO) && (!valid_q || coef_ready);
        drain = (remaining_q == REM_ZERO) && (!valid_q || coef_ready);
        if (load) begin
          data_d      = output_data;
          valid_d     = 1'b1;
          last_d      = (remaining_q == REM_ONE);
          remaining_d = remaining_q - REM_ONE;
          addr_d      = step_addr(addr_q, dir_q);
        end else if (drain) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        // Start is still ignored here because busy remains high this cycle.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign read_address = addr_q;
  assign coef_data    = data_q;
  assign coef_valid   = valid_q;
  assign coef_last    = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
